// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer on the CPU data bus.
// Register window at BASE: CTRL (+0), PRESET (+4), COUNT (+8, read-only).
// Optional macro TIMER_BYTEEN_EN: when defined, CTRL/PRESET writes honour
// per-byte enables; otherwise any nonzero byteen writes the full word.
module mips_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q;

  logic        hit, wr, ctrl_wr, preset_wr;
  logic        en, auto_mode;
  logic        unused_addr_lsb;

  // Word-granular decode; the low address bits carry no meaning here.
  assign unused_addr_lsb = ^addr[1:0];
  assign hit       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
  assign wr        = hit && (byteen != 4'b0000);
`ifdef TIMER_BYTEEN_EN
  assign ctrl_wr   = wr && (addr[3:2] == 2'b00) && byteen[0];
`else
  assign ctrl_wr   = wr && (addr[3:2] == 2'b00);
`endif
  assign preset_wr = wr && (addr[3:2] == 2'b01);

  assign en        = ctrl_q[0];
  assign auto_mode = (ctrl_q[2:1] == 2'b01);

  // Combinational read mux with no side effects.
  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (addr[3:2])
        2'b00:   rdata = {28'h0, ctrl_q};
        2'b01:   rdata = preset_q;
        2'b10:   rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: state_d = S_CNT;
      S_CNT: begin
        if (!en)                state_d = S_IDLE;
        else if (count_q <= 1) state_d = S_INT;
      end
      S_INT:   state_d = auto_mode ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: datapath updates, then bus writes override them.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    unique case (state_q)
      S_LOAD: count_d = preset_q;
      S_CNT: begin
        if (en) begin
          if (count_q > 1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            flag_d  = 1'b1;
          end
        end
      end
      S_INT: begin
        if (auto_mode) flag_d    = 1'b0;
        else           ctrl_d[0] = 1'b0;
      end
      default: ;
    endcase
    // A bus write to CTRL takes priority over the hardware EN clear and
    // over an interrupt being raised on the same edge.
    if (ctrl_wr) begin
      ctrl_d = wdata[3:0];
      flag_d = 1'b0;
    end
    if (preset_wr) begin
`ifdef TIMER_BYTEEN_EN
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
`else
      preset_d = wdata;
`endif
    end
  end

  // Datapath registers; irq is registered from next-state values so it has
  // the same timing as int_flag & IM while coming straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= flag_d & ctrl_d[3];
    end
  end

  assign irq = irq_q;

endmodule
